f_fetch_ctrl: RTL and testbench

F-stage fetch sequencer for the pipelined MIPS core. It owns the F-stage PC register and advances it from the D-stage next-PC unit output `D_npc`. It drives a request/acknowledge instruction-memory port with variable latency and holds the fetched instruction while the hazard unit stalls F/D. It hands exactly one instruction per accepted fetch to the F/D register and keeps a wrapping count of handed-off instructions.

---
 rtl/f_fetch_ctrl.sv | 87 ++++++++
 tb/tb_f_fetch_ctrl.sv | 377 +++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/f_fetch_ctrl.sv
// F-stage fetch sequencer: owns F_PC, issues imem requests, buffers the word across F/D stalls.
// Latency: zero-wait memory is bypassed to F_instr in the ack cycle; N-cycle memory offers after N cycles.
// Backpressure: stall during ack parks the word in HOLD with no refetch; imem_req drops while holding.
module f_fetch_ctrl #(
    parameter logic [31:0] RESET_PC = 32'h0000_3000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] D_npc,
    input  logic        stall,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ack,
    input  logic [31:0] imem_rdata,
    output logic [31:0] F_PC,
    output logic [31:0] F_instr,
    output logic        F_valid,
    output logic [31:0] F_fetch_cnt
);

    typedef enum logic {
        REQ  = 1'b0,
        HOLD = 1'b1
    } state_t;

    state_t      state;
    state_t      state_nxt;
    logic [31:0] buf_q;
    logic        capture;
    logic        handoff;
    logic        unused_npc_lsb;

    // Targets are word aligned by truncation; the dropped bits are intentionally ignored.
    assign unused_npc_lsb = ^D_npc[1:0];
    assign imem_addr      = F_PC;

    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= REQ;
            F_PC        <= RESET_PC;
            buf_q       <= 32'h0;
            F_fetch_cnt <= 32'h0;
        end else begin
            state <= state_nxt;
            if (capture) begin
                buf_q <= imem_rdata;
            end
            if (handoff) begin
                F_PC        <= {D_npc[31:2], 2'b00};
                F_fetch_cnt <= F_fetch_cnt + 32'd1;
            end
        end
    end

    always_comb begin
        state_nxt = state;
        imem_req  = 1'b0;
        F_valid   = 1'b0;
        F_instr   = 32'h0;
        capture   = 1'b0;
        if (!reset) begin
            case (state)
                REQ: begin
                    imem_req = 1'b1;
                    if (imem_ack) begin
                        F_valid = 1'b1;
                        F_instr = imem_rdata;
                        if (stall) begin
                            capture   = 1'b1;
                            state_nxt = HOLD;
                        end
                    end
                end
                HOLD: begin
                    F_valid = 1'b1;
                    F_instr = buf_q;
                    if (!stall) begin
                        state_nxt = REQ;
                    end
                end
                default: state_nxt = REQ;
            endcase
        end
        handoff = F_valid && !stall;
    end

endmodule

// File: tb/tb_f_fetch_ctrl.sv
// Scenario bench for f_fetch_ctrl: a scoreboard queue holds each word accepted from memory
// and is popped when the DUT hands an instruction to D.
module tb_f_fetch_ctrl;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] D_npc;
    logic        stall;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack;
    logic [31:0] imem_rdata;
    logic [31:0] F_PC;
    logic [31:0] F_instr;
    logic        F_valid;
    logic [31:0] F_fetch_cnt;

    always #5 clk = ~clk;

    f_fetch_ctrl #(.RESET_PC(32'h0000_3000)) dut (
        .clk        (clk),
        .reset      (reset),
        .D_npc      (D_npc),
        .stall      (stall),
        .imem_req   (imem_req),
        .imem_addr  (imem_addr),
        .imem_ack   (imem_ack),
        .imem_rdata (imem_rdata),
        .F_PC       (F_PC),
        .F_instr    (F_instr),
        .F_valid    (F_valid),
        .F_fetch_cnt(F_fetch_cnt)
    );

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
    } exp_t;

    exp_t        sb[$];
    exp_t        e;
    int          n_checks = 0;
    int          n_fail   = 0;
    logic [31:0] m_pc;
    logic [31:0] m_cnt;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return a ^ 32'h2400_BEEF;
    endfunction

    // Zero-wait sequential handoffs used only to walk F_PC to a scenario's start address.
    task automatic seq_handoff(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            imem_ack   = 1'b1;
            imem_rdata = mem_word(m_pc);
            stall      = 1'b0;
            D_npc      = m_pc + 32'd4;
            m_pc       = m_pc + 32'd4;
            m_cnt      = m_cnt + 32'd1;
        end
    endtask

    task automatic test_reset();
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            reset = 1'b1; imem_ack = 1'b0; stall = 1'b0; D_npc = 32'h0; imem_rdata = 32'h0;
            #1;
            n_checks++;
            if (imem_req !== 1'b0 || F_valid !== 1'b0 || F_instr !== 32'h0) begin
                n_fail++;
                $display("FAIL reset_outputs: req=%0b valid=%0b instr=%h, want 0/0/0", imem_req, F_valid, F_instr);
            end
        end
        @(negedge clk);
        reset = 1'b0; imem_ack = 1'b0;
        #1;
        n_checks++;
        if (imem_req !== 1'b1 || imem_addr !== 32'h3000 || F_PC !== 32'h3000 || F_fetch_cnt !== 32'h0 || F_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_first_req: req=%0b addr=%h pc=%h cnt=%0d valid=%0b, want 1/3000/3000/0/0",
                     imem_req, imem_addr, F_PC, F_fetch_cnt, F_valid);
        end
        m_pc = 32'h3000; m_cnt = 32'h0;
    endtask

    task automatic test_sequential();
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            n_checks++;
            if (F_PC !== m_pc) begin
                n_fail++;
                $display("FAIL seq_pc[%0d]: got %h want %h", i, F_PC, m_pc);
            end
            imem_ack = 1'b1; imem_rdata = mem_word(m_pc); stall = 1'b0; D_npc = m_pc + 32'd4;
            sb.push_back('{pc: m_pc, instr: mem_word(m_pc)});
            #1;
            n_checks++;
            if (imem_req !== 1'b1 || imem_addr !== m_pc || F_valid !== 1'b1) begin
                n_fail++;
                $display("FAIL seq_req[%0d]: req=%0b addr=%h valid=%0b, want 1/%h/1", i, imem_req, imem_addr, F_valid, m_pc);
            end
            if (F_valid && !stall) begin
                n_checks++;
                if (sb.size() == 0) begin
                    n_fail++;
                    $display("FAIL seq_sb: handoff with empty scoreboard, instr=%h", F_instr);
                end else begin
                    e = sb.pop_front();
                    if (F_instr !== e.instr || F_PC !== e.pc) begin
                        n_fail++;
                        $display("FAIL seq_handoff: instr=%h pc=%h want %h/%h", F_instr, F_PC, e.instr, e.pc);
                    end
                end
            end
            m_pc = m_pc + 32'd4; m_cnt = m_cnt + 32'd1;
        end
        @(negedge clk);
        imem_ack = 1'b0;
        #1;
        n_checks++;
        if (F_fetch_cnt !== 32'd3 || F_PC !== 32'h300C) begin
            n_fail++;
            $display("FAIL seq_cnt: cnt=%0d pc=%h want 3/300c", F_fetch_cnt, F_PC);
        end
    endtask

    task automatic test_wait_states();
        @(negedge clk);
        reset = 1'b1; imem_ack = 1'b0;
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            reset = 1'b0; imem_ack = 1'b0; imem_rdata = 32'hFFFF_0000; stall = 1'b0;
            #1;
            n_checks++;
            if (imem_req !== 1'b1 || imem_addr !== 32'h3000 || F_valid !== 1'b0 || F_instr !== 32'h0) begin
                n_fail++;
                $display("FAIL wait_idle[%0d]: req=%0b addr=%h valid=%0b instr=%h, want 1/3000/0/0",
                         i, imem_req, imem_addr, F_valid, F_instr);
            end
        end
        m_pc = 32'h3000; m_cnt = 32'h0;
        @(negedge clk);
        imem_ack = 1'b1; imem_rdata = mem_word(m_pc); D_npc = m_pc + 32'd4;
        sb.push_back('{pc: m_pc, instr: mem_word(m_pc)});
        #1;
        n_checks++;
        if (sb.size() == 0 || F_valid !== 1'b1 || imem_addr !== 32'h3000) begin
            n_fail++;
            $display("FAIL wait_ack: valid=%0b addr=%h, want 1/3000", F_valid, imem_addr);
        end else begin
            e = sb.pop_front();
            if (F_instr !== e.instr) begin
                n_fail++;
                $display("FAIL wait_ack_instr: got %h want %h", F_instr, e.instr);
            end
        end
        m_pc = 32'h3004; m_cnt = 32'd1;
        @(negedge clk);
        imem_ack = 1'b0;
        #1;
        n_checks++;
        if (imem_addr !== 32'h3004 || F_PC !== 32'h3004 || F_fetch_cnt !== 32'd1) begin
            n_fail++;
            $display("FAIL wait_next: addr=%h pc=%h cnt=%0d want 3004/3004/1", imem_addr, F_PC, F_fetch_cnt);
        end
    endtask

    task automatic test_stall_at_ack();
        @(negedge clk);
        imem_ack = 1'b1; imem_rdata = 32'h2408_0001; stall = 1'b1; D_npc = 32'hDEAD_BEE0;
        sb.push_back('{pc: m_pc, instr: 32'h2408_0001});
        #1;
        n_checks++;
        if (imem_req !== 1'b1 || F_valid !== 1'b1 || F_instr !== 32'h2408_0001) begin
            n_fail++;
            $display("FAIL stall_ack: req=%0b valid=%0b instr=%h want 1/1/24080001", imem_req, F_valid, F_instr);
        end
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            imem_ack = 1'b0; imem_rdata = $urandom; stall = 1'b1;
            #1;
            n_checks++;
            if (imem_req !== 1'b0 || F_valid !== 1'b1 || F_instr !== 32'h2408_0001 ||
                F_PC !== m_pc || F_fetch_cnt !== m_cnt) begin
                n_fail++;
                $display("FAIL stall_hold[%0d]: req=%0b valid=%0b instr=%h pc=%h cnt=%0d want 0/1/24080001/%h/%0d",
                         i, imem_req, F_valid, F_instr, F_PC, F_fetch_cnt, m_pc, m_cnt);
            end
        end
        @(negedge clk);
        stall = 1'b0; D_npc = m_pc + 32'd4;
        #1;
        n_checks++;
        if (sb.size() == 0 || F_valid !== 1'b1 || imem_req !== 1'b0) begin
            n_fail++;
            $display("FAIL stall_release: valid=%0b req=%0b want 1/0", F_valid, imem_req);
        end else begin
            e = sb.pop_front();
            if (F_instr !== e.instr || F_PC !== e.pc) begin
                n_fail++;
                $display("FAIL stall_release_data: instr=%h pc=%h want %h/%h", F_instr, F_PC, e.instr, e.pc);
            end
        end
        m_pc = m_pc + 32'd4; m_cnt = m_cnt + 32'd1;
        @(negedge clk);
        imem_ack = 1'b0; stall = 1'b0;
        #1;
        n_checks++;
        if (imem_req !== 1'b1 || F_PC !== m_pc || F_fetch_cnt !== m_cnt) begin
            n_fail++;
            $display("FAIL stall_after: req=%0b pc=%h cnt=%0d want 1/%h/%0d", imem_req, F_PC, F_fetch_cnt, m_pc, m_cnt);
        end
    endtask

    task automatic test_redirect();
        seq_handoff(int'((32'h3010 - m_pc) >> 2));
        @(negedge clk);
        imem_ack = 1'b1; imem_rdata = mem_word(m_pc); stall = 1'b0; D_npc = 32'h3100;
        #1;
        n_checks++;
        if (imem_addr !== 32'h3010 || F_valid !== 1'b1 || F_instr !== mem_word(32'h3010)) begin
            n_fail++;
            $display("FAIL redir_slot: addr=%h valid=%0b instr=%h want 3010/1/%h", imem_addr, F_valid, F_instr, mem_word(32'h3010));
        end
        @(negedge clk);
        n_checks++;
        if (F_PC !== 32'h3100) begin
            n_fail++;
            $display("FAIL redir_target: pc=%h want 3100", F_PC);
        end
        imem_ack = 1'b1; imem_rdata = mem_word(32'h3100); D_npc = 32'h3003;
        @(negedge clk);
        imem_ack = 1'b0;
        #1;
        n_checks++;
        if (F_PC !== 32'h3000 || imem_addr !== 32'h3000) begin
            n_fail++;
            $display("FAIL redir_align: pc=%h addr=%h want 3000/3000", F_PC, imem_addr);
        end
        m_pc = 32'h3000; m_cnt = m_cnt + 32'd2;
    endtask

    task automatic test_reset_mid_request();
        seq_handoff(8);
        @(negedge clk);
        imem_ack = 1'b0;
        #1;
        n_checks++;
        if (imem_addr !== 32'h3020 || imem_req !== 1'b1 || F_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL rmid_pending: addr=%h req=%0b valid=%0b want 3020/1/0", imem_addr, imem_req, F_valid);
        end
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            reset = 1'b1; imem_ack = 1'b1; imem_rdata = $urandom; stall = 1'b0; D_npc = 32'h3024;
            #1;
            n_checks++;
            if (imem_req !== 1'b0 || F_valid !== 1'b0) begin
                n_fail++;
                $display("FAIL rmid_in_reset[%0d]: req=%0b valid=%0b want 0/0", i, imem_req, F_valid);
            end
        end
        @(negedge clk);
        reset = 1'b0; imem_ack = 1'b0;
        #1;
        n_checks++;
        if (F_PC !== 32'h3000 || imem_addr !== 32'h3000 || F_fetch_cnt !== 32'h0 || imem_req !== 1'b1 || F_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL rmid_after: pc=%h addr=%h cnt=%0d req=%0b valid=%0b want 3000/3000/0/1/0",
                     F_PC, imem_addr, F_fetch_cnt, imem_req, F_valid);
        end
        m_pc = 32'h3000; m_cnt = 32'h0;
    endtask

    task automatic test_counter_wrap();
        @(negedge clk);
        imem_ack = 1'b0; stall = 1'b0;
        force dut.F_fetch_cnt = 32'hFFFF_FFFF;
        @(negedge clk);
        release dut.F_fetch_cnt;
        imem_ack = 1'b1; imem_rdata = mem_word(m_pc); D_npc = m_pc + 32'd4;
        @(negedge clk);
        imem_ack = 1'b0;
        #1;
        n_checks++;
        if (F_fetch_cnt !== 32'h0 || F_PC !== m_pc + 32'd4) begin
            n_fail++;
            $display("FAIL cnt_wrap: cnt=%h pc=%h want 0/%h", F_fetch_cnt, F_PC, m_pc + 32'd4);
        end
        m_pc = m_pc + 32'd4; m_cnt = 32'h0;
    endtask

    // Random acks, stalls and redirects against a reference model of REQ/HOLD.
    task automatic test_back_to_back();
        logic        m_hold;
        logic [31:0] m_buf;
        logic        exp_vld;
        logic [31:0] exp_ins;
        m_hold = 1'b0; m_buf = 32'h0;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            n_checks++;
            if (F_PC !== m_pc || F_fetch_cnt !== m_cnt) begin
                n_fail++;
                $display("FAIL b2b_regs[%0d]: pc=%h cnt=%0d want %h/%0d", i, F_PC, F_fetch_cnt, m_pc, m_cnt);
            end
            stall      = ($urandom_range(0, 2) == 0);
            imem_rdata = $urandom;
            imem_ack   = m_hold ? 1'b0 : 1'($urandom_range(0, 1));
            D_npc      = ($urandom_range(0, 3) == 0) ? $urandom : m_pc + 32'd4;
            exp_vld    = m_hold | imem_ack;
            exp_ins    = m_hold ? m_buf : (imem_ack ? imem_rdata : 32'h0);
            if (!m_hold && imem_ack) begin
                sb.push_back('{pc: m_pc, instr: imem_rdata});
            end
            #1;
            n_checks++;
            if (imem_req !== !m_hold || imem_addr !== m_pc || F_valid !== exp_vld || F_instr !== exp_ins) begin
                n_fail++;
                $display("FAIL b2b_comb[%0d]: req=%0b addr=%h valid=%0b instr=%h want %0b/%h/%0b/%h",
                         i, imem_req, imem_addr, F_valid, F_instr, !m_hold, m_pc, exp_vld, exp_ins);
            end
            if (F_valid && !stall) begin
                n_checks++;
                if (sb.size() == 0) begin
                    n_fail++;
                    $display("FAIL b2b_sb[%0d]: handoff with empty scoreboard, instr=%h", i, F_instr);
                end else begin
                    e = sb.pop_front();
                    if (F_instr !== e.instr || F_PC !== e.pc) begin
                        n_fail++;
                        $display("FAIL b2b_handoff[%0d]: instr=%h pc=%h want %h/%h", i, F_instr, F_PC, e.instr, e.pc);
                    end
                end
            end
            if (exp_vld && !stall) begin
                m_pc   = {D_npc[31:2], 2'b00};
                m_cnt  = m_cnt + 32'd1;
                m_hold = 1'b0;
            end else if (!m_hold && imem_ack && stall) begin
                m_hold = 1'b1;
                m_buf  = imem_rdata;
            end
        end
        @(negedge clk);
        imem_ack = 1'b0; stall = 1'b1;
        #1;
        n_checks++;
        if (sb.size() > 1 || F_PC !== m_pc || F_fetch_cnt !== m_cnt) begin
            n_fail++;
            $display("FAIL b2b_end: sb=%0d pc=%h cnt=%0d want <=1/%h/%0d", sb.size(), F_PC, F_fetch_cnt, m_pc, m_cnt);
        end
    endtask

    initial begin
        reset = 1'b1; D_npc = 32'h0; stall = 1'b0; imem_ack = 1'b0; imem_rdata = 32'h0;
        m_pc = 32'h3000; m_cnt = 32'h0;
        test_reset();
        test_sequential();
        test_wait_states();
        test_stall_at_ack();
        test_redirect();
        test_reset_mid_request();
        test_counter_wrap();
        test_back_to_back();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule
